mnist_stream_loader: RTL and testbench

- Upstream sequencer for the MNIST inference core (mem_sys plus compute_module behind a load/compute mux).
- Accepts a 1-bit serial stream over a valid/ready handshake: all weight bits first, then all input-image bits.
- Writes each bit through the core's load-mode port set, then releases load mode and enables compute.
- Waits for compute_finish, then captures and holds the 4-bit classification result.

---
 rtl/mnist_stream_loader.sv | 201 ++++++++++++++++++++
 tb/tb_mnist_stream_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mnist_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : mnist_stream_loader
// Brief    : Serial weight/image loader and compute sequencer for the MNIST core
// Revision : 1.0
// ============================================================================
module mnist_stream_loader #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int W_COUNT    = 7840,
  parameter int X_COUNT    = 784,
  parameter int W_SEL_LOAD = 0,
  parameter int X_SEL_LOAD = 0,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  in_ready,
  output logic                  load_compute_ctrl,
  output logic                  en_compute,
  output logic                  w_wq_oc,
  output logic                  x_wq_oc,
  output logic [W_ADDR_LEN-1:0] w_addr_oc,
  output logic [X_ADDR_LEN-1:0] x_addr_oc,
  output logic                  wx_write_oc,
  output logic [W_SEL_LEN-1:0]  w_sel_oc,
  output logic [X_SEL_LEN-1:0]  x_sel_oc,
  input  logic                  compute_finish,
  input  logic [3:0]            result_in,
  output logic [3:0]            result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  error
);

  localparam int c_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W_ADDR_LEN-1:0] c_W_LAST  = W_ADDR_LEN'(W_COUNT - 1);
  localparam logic [X_ADDR_LEN-1:0] c_X_LAST  = X_ADDR_LEN'(X_COUNT - 1);
  localparam logic [c_TMR_W-1:0]    c_T_LAST  = c_TMR_W'(TIMEOUT - 1);
  localparam logic [W_SEL_LEN-1:0]  c_W_SEL   = W_SEL_LEN'(W_SEL_LOAD);
  localparam logic [X_SEL_LEN-1:0]  c_X_SEL   = X_SEL_LEN'(X_SEL_LOAD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [W_ADDR_LEN-1:0] r_wcnt, w_wcnt_nxt, r_w_addr, w_w_addr_nxt;
  logic [X_ADDR_LEN-1:0] r_xcnt, w_xcnt_nxt, r_x_addr, w_x_addr_nxt;
  logic [c_TMR_W-1:0]    r_tmr, w_tmr_nxt;
  logic                  r_lcc, w_lcc_nxt, r_en, w_en_nxt;
  logic                  r_w_wq, w_w_wq_nxt, r_x_wq, w_x_wq_nxt;
  logic                  r_wx, w_wx_nxt;
  logic [3:0]            r_result, w_result_nxt;
  logic                  r_rvalid, w_rvalid_nxt, r_error, w_error_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [W_SEL_LEN-1:0]  r_w_sel;
  logic [X_SEL_LEN-1:0]  r_x_sel;
  logic                  w_accept;

  assign in_ready = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_X);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_xcnt_nxt   = r_xcnt;
    w_tmr_nxt    = r_tmr;
    w_lcc_nxt    = r_lcc;
    w_en_nxt     = r_en;
    w_w_wq_nxt   = 1'b0;
    w_x_wq_nxt   = 1'b0;
    w_w_addr_nxt = r_w_addr;
    w_x_addr_nxt = r_x_addr;
    w_wx_nxt     = r_wx;
    w_result_nxt = r_result;
    w_rvalid_nxt = r_rvalid;
    w_error_nxt  = r_error;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt  = ST_LOAD_W;
          w_rvalid_nxt = 1'b0;
          w_error_nxt  = 1'b0;
          w_wcnt_nxt   = '0;
          w_xcnt_nxt   = '0;
        end
      end
      ST_LOAD_W: begin
        if (w_accept) begin
          w_w_wq_nxt   = 1'b1;
          w_w_addr_nxt = r_wcnt;
          w_wx_nxt     = in_bit;
          // Counter parks on the terminal value so it never wraps.
          if (r_wcnt == c_W_LAST) w_state_nxt = ST_LOAD_X;
          else                    w_wcnt_nxt  = r_wcnt + W_ADDR_LEN'(1);
        end
      end
      ST_LOAD_X: begin
        if (w_accept) begin
          w_x_wq_nxt   = 1'b1;
          w_x_addr_nxt = r_xcnt;
          w_wx_nxt     = in_bit;
          if (r_xcnt == c_X_LAST) w_state_nxt = ST_START;
          else                    w_xcnt_nxt  = r_xcnt + X_ADDR_LEN'(1);
        end
      end
      ST_START: begin
        w_lcc_nxt   = 1'b0;
        w_en_nxt    = 1'b1;
        w_tmr_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A finish in the last timeout cycle still wins over the error.
        if (compute_finish) begin
          w_result_nxt = result_in;
          w_rvalid_nxt = 1'b1;
          w_en_nxt     = 1'b0;
          w_lcc_nxt    = 1'b1;
          w_state_nxt  = ST_DONE;
        end else if (r_tmr == c_T_LAST) begin
          w_error_nxt  = 1'b1;
          w_en_nxt     = 1'b0;
          w_lcc_nxt    = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_tmr_nxt    = r_tmr + c_TMR_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wcnt   <= '0;
      r_xcnt   <= '0;
      r_tmr    <= '0;
      r_lcc    <= 1'b1;
      r_en     <= 1'b0;
      r_w_wq   <= 1'b0;
      r_x_wq   <= 1'b0;
      r_w_addr <= '0;
      r_x_addr <= '0;
      r_wx     <= 1'b0;
      r_result <= '0;
      r_rvalid <= 1'b0;
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
      r_w_sel  <= c_W_SEL;
      r_x_sel  <= c_X_SEL;
    end else begin
      r_state  <= w_state_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_xcnt   <= w_xcnt_nxt;
      r_tmr    <= w_tmr_nxt;
      r_lcc    <= w_lcc_nxt;
      r_en     <= w_en_nxt;
      r_w_wq   <= w_w_wq_nxt;
      r_x_wq   <= w_x_wq_nxt;
      r_w_addr <= w_w_addr_nxt;
      r_x_addr <= w_x_addr_nxt;
      r_wx     <= w_wx_nxt;
      r_result <= w_result_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_error  <= w_error_nxt;
      r_busy   <= w_busy_nxt;
      r_w_sel  <= c_W_SEL;
      r_x_sel  <= c_X_SEL;
    end
  end

  assign load_compute_ctrl = r_lcc;
  assign en_compute        = r_en;
  assign w_wq_oc           = r_w_wq;
  assign x_wq_oc           = r_x_wq;
  assign w_addr_oc         = r_w_addr;
  assign x_addr_oc         = r_x_addr;
  assign wx_write_oc       = r_wx;
  assign w_sel_oc          = r_w_sel;
  assign x_sel_oc          = r_x_sel;
  assign result            = r_result;
  assign result_valid      = r_rvalid;
  assign busy              = r_busy;
  assign error             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mnist_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mnist_stream_loader
// Brief    : Randomized self-checking bench for mnist_stream_loader
// Revision : 1.0
// ============================================================================
module tb_mnist_stream_loader;

  localparam int c_W_CNT = 4;
  localparam int c_X_CNT = 3;
  localparam int c_TMO   = 16;
  localparam int c_TOTAL = c_W_CNT + c_X_CNT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       compute_finish = 1'b0;
  logic [3:0] result_in = 4'd0;
  logic       in_ready, load_compute_ctrl, en_compute, w_wq_oc, x_wq_oc, wx_write_oc;
  logic [3:0] w_addr_oc;
  logic [2:0] x_addr_oc;
  logic [1:0] w_sel_oc, x_sel_oc;
  logic [3:0] result;
  logic       result_valid, busy, error;

  mnist_stream_loader #(
    .W_ADDR_LEN(4), .X_ADDR_LEN(3), .W_SEL_LEN(2), .X_SEL_LEN(2),
    .W_COUNT(c_W_CNT), .X_COUNT(c_X_CNT), .W_SEL_LOAD(2), .X_SEL_LOAD(1),
    .TIMEOUT(c_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .load_compute_ctrl(load_compute_ctrl), .en_compute(en_compute),
    .w_wq_oc(w_wq_oc), .x_wq_oc(x_wq_oc), .w_addr_oc(w_addr_oc), .x_addr_oc(x_addr_oc),
    .wx_write_oc(wx_write_oc), .w_sel_oc(w_sel_oc), .x_sel_oc(x_sel_oc),
    .compute_finish(compute_finish), .result_in(result_in), .result(result),
    .result_valid(result_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: progress of a run expressed as bits accepted and edges elapsed.
  bit         m_run;
  int         m_acc, m_post, m_wait;
  logic       e_lcc, e_en, e_wwq, e_xwq, e_wx, e_rvalid, e_busy, e_error;
  logic [3:0] e_waddr, e_result;
  logic [2:0] e_xaddr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_acc = 0; m_post = -1; m_wait = 0;
    e_lcc = 1'b1; e_en = 1'b0; e_wwq = 1'b0; e_xwq = 1'b0; e_wx = 1'b0;
    e_rvalid = 1'b0; e_busy = 1'b0; e_error = 1'b0;
    e_waddr = 4'd0; e_xaddr = 3'd0; e_result = 4'd0;
  endtask

  task automatic check_outputs();
    check("load_compute_ctrl", load_compute_ctrl, e_lcc);
    check("en_compute", en_compute, e_en);
    check("w_wq_oc", w_wq_oc, e_wwq);
    check("x_wq_oc", x_wq_oc, e_xwq);
    check("w_addr_oc", w_addr_oc, e_waddr);
    check("x_addr_oc", x_addr_oc, e_xaddr);
    check("wx_write_oc", wx_write_oc, e_wx);
    check("w_sel_oc", w_sel_oc, 2);
    check("x_sel_oc", x_sel_oc, 1);
    check("result", result, e_result);
    check("result_valid", result_valid, e_rvalid);
    check("busy", busy, e_busy);
    check("error", error, e_error);
  endtask

  // Called at a falling edge: drive inputs, advance the model one edge, check.
  task automatic tick(input logic v, input logic b, input logic s, input logic f,
                      input logic [3:0] r);
    logic exp_ready;
    in_valid = v; in_bit = b; start = s; compute_finish = f; result_in = r;
    exp_ready = m_run && (m_acc < c_TOTAL);
    check("in_ready", in_ready, exp_ready);
    e_wwq = 1'b0;
    e_xwq = 1'b0;
    if (!m_run) begin
      if (s) begin
        m_run = 1'b1; m_acc = 0; m_post = -1; m_wait = 0;
        e_rvalid = 1'b0; e_error = 1'b0;
      end
    end else if (m_acc < c_TOTAL) begin
      if (v) begin
        if (m_acc < c_W_CNT) begin e_wwq = 1'b1; e_waddr = 4'(m_acc); end
        else begin e_xwq = 1'b1; e_xaddr = 3'(m_acc - c_W_CNT); end
        e_wx = b;
        m_acc++;
        if (m_acc == c_TOTAL) m_post = 0;
      end
    end else if (m_post == 0) begin
      m_post = 1; e_lcc = 1'b0; e_en = 1'b1;
    end else begin
      m_wait++;
      if (f) begin
        e_result = r; e_rvalid = 1'b1; e_en = 1'b0; e_lcc = 1'b1; m_run = 1'b0;
      end else if (m_wait == c_TMO) begin
        e_error = 1'b1; e_en = 1'b0; e_lcc = 1'b1; m_run = 1'b0;
      end
    end
    e_busy = m_run;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // vmode: 0 valid always, 1 toggling, 2 random. lat < 0: core never finishes.
  task automatic do_run(input int vmode, input logic [6:0] dbits, input bit use_dir,
                        input int lat, input logic [3:0] res, input bit stale, input bit poke);
    int   guard;
    int   cyc;
    logic v, b, s, f;
    guard = 0;
    cyc   = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    while (m_run && m_acc < c_TOTAL && guard < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      b = use_dir ? dbits[m_acc] : 1'($urandom_range(0, 1));
      s = poke && (m_acc >= c_W_CNT) && ($urandom_range(0, 1) == 1);
      tick(v, b, s, stale, 4'($urandom));
      cyc++;
      guard++;
    end
    while (m_run && guard < 200) begin
      f = (stale && m_post < 1) || (m_post >= 1 && lat >= 0 && m_wait >= lat);
      s = poke && ($urandom_range(0, 1) == 1);
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, f,
           f ? res : 4'($urandom));
      guard++;
    end
    check("run_cycle_budget", 32'(guard < 200), 32'd1);
    tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1'b0);
    check_outputs();
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // Abort part-way through the weight load.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("abort_in_ready", in_ready, 1'b0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // w bits 1,0,1,1 then x bits 0,1,0
    do_run(0, 7'b0101101, 1'b1, 5, 4'd7, 1'b0, 1'b0);
    do_run(1, 7'b0101101, 1'b1, 5, 4'd7, 1'b0, 1'b0);
    do_run(2, 7'b0, 1'b0, -1, 4'd0, 1'b1, 1'b0);
    do_run(0, 7'b0, 1'b0, 3, 4'd12, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      do_run($urandom_range(0, 2), 7'b0, 1'b0, $urandom_range(0, 20),
             4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
